fx3_bulkin_mux: RTL and testbench
=================================

# fx3_bulkin_mux

Multi-channel bulk-in writer for the FX3 slave FIFO in the fx3_clk domain. Generalises the single-socket loader/data-interface pair: CH_NUM independent ready/valid streams of DATA_W bits are arbitrated round-robin at FX3-packet granularity, each routed to its own FX3 socket via fx3_a. Adds flag-latency handling, short-packet commit via fx3_pktend_n, and per-channel transfer-done reporting. Sits between the per-subsystem buffers and the FX3 pins.

## Interface
Parameters:
- CH_NUM, 2, number of channels/sockets (1..4); channel i uses socket address i
- DATA_W, 32, FX3 GPIF bus width (8, 16 or 32)
- PKT_WORDS, 256, words per full FX3 packet (2..4096)
- FLAG_LAT, 3, cycles from fx3_a change to valid fx3_flaga (1..7)
- GAP_CYC, 2, idle cycles after each packet before re-arbitration (1..7)
- TIMEOUT_CYC, 1024, starvation limit for timeout commit (used only with FX3_PKTEND_TIMEOUT_EN)

Ports:
- fx3_clk  in  1  sole clock
- fx3_rst  in  1  reset; synchronous, active-high
- frame_rst_fx3  in  1  synchronous abort/clear, same effect as fx3_rst
- ch_vld  in  CH_NUM  per-channel data valid
- ch_data  in  CH_NUM*DATA_W  channel i at [i*DATA_W +: DATA_W]
- ch_last  in  CH_NUM  marks final word of a transfer
- ch_rdy  out  CH_NUM  per-channel accept
- ch_done  out  CH_NUM  one-cycle pulse: transfer end written
- fx3_flaga  in  1  1 = addressed socket can take PKT_WORDS words
- fx3_a  out  2  socket address
- fx3_dout  out  DATA_W  write data
- fx3_slwr_n  out  1  write strobe, active low
- fx3_pktend_n  out  1  packet end, active low
- busy  out  1  state not IDLE
- word_cnt  out  32  total words written since reset, wraps at 2^32

## Operation
- States: IDLE, ADDR, CHECK, WRITE, GAP.
- IDLE: if any ch_vld, grant g = first channel with ch_vld searching from ptr upward mod CH_NUM; latch g, drive fx3_a=g, load wait counter, -> ADDR. ptr=0 after reset.
- ADDR: wait FLAG_LAT cycles, -> CHECK.
- CHECK: fx3_flaga=1 -> WRITE, pkt_cnt=0; else ptr=g+1, -> GAP (no write, no pktend).
- WRITE: ch_rdy[g]=1, all other ch_rdy=0. Each cycle with ch_vld[g]: word accepted, pkt_cnt+1.
  - accepted word with pkt_cnt reaching PKT_WORDS: -> GAP (full packet auto-commits, no pktend).
  - accepted word with ch_last and pkt_cnt+1 < PKT_WORDS: pktend_n low with that word's slwr_n, -> GAP.
  - ch_last on word PKT_WORDS: no pktend; ch_done still pulses.
  - exit from WRITE sets ptr=g+1.
- GAP: slwr_n=1, hold GAP_CYC cycles, -> IDLE.
- ch_done[g] pulses in the cycle slwr_n is low for a ch_last word.
- fx3_rst or frame_rst_fx3 in any state: -> IDLE next cycle, ptr=0, word_cnt=0, partial packet abandoned without pktend.
- ch_vld on a non-granted channel is ignored until its turn; channels are never starved (round-robin).
- CH_NUM=1: arbitration degenerates to channel 0 every packet.

## Timing
- Reset values: fx3_slwr_n=1, fx3_pktend_n=1, fx3_a=0, fx3_dout=0, ch_rdy=0, ch_done=0, busy=0, word_cnt=0.
- All outputs registered; ch_rdy decoded from registered state/grant only (no input-to-ready combinational path).
- Accept-to-pin latency: word accepted at edge N appears on fx3_dout with fx3_slwr_n=0 during cycle N+1; word_cnt increments same cycle.
- Best-case arbitration overhead: 1 (IDLE) + FLAG_LAT + 1 (CHECK) cycles before first ch_rdy.
- Back-to-back full packets: PKT_WORDS + GAP_CYC + FLAG_LAT + 2 cycles per packet.
- fx3_a stable from IDLE exit until GAP end.

## Configuration
- FX3_PKTEND_TIMEOUT_EN defined: in WRITE, counter of consecutive cycles with ch_vld[g]=0; at TIMEOUT_CYC with pkt_cnt>0, one cycle fx3_pktend_n=0 with fx3_slwr_n=1 (short-packet commit), no ch_done, -> GAP. Counter clears on any accept. pkt_cnt=0 never times out.
- Not defined: no timeout counter; WRITE waits indefinitely for data; TIMEOUT_CYC ignored.

## Test plan
- CH_NUM=2, PKT_WORDS=16, flaga=1, ch0 streams 32 words, last on 32nd -> two 16-word bursts on socket 0, no pktend, ch_done[0] once, word_cnt=32.
- ch0 and ch1 both continuously valid -> sockets alternate 0,1,0,1 per packet; each burst exactly 16 slwr_n lows.
- ch1 sends 5 words with last on 5th -> pktend_n low with 5th slwr_n, ch_done[1] same cycle.
- flaga=0 during CHECK for ch0 while ch1 valid -> no writes to socket 0, next grant ch1.
- frame_rst_fx3 after 7 words of a packet -> slwr_n=1 next cycle, no pktend, busy=0, word_cnt=0.
- With FX3_PKTEND_TIMEOUT_EN, TIMEOUT_CYC=8: 3 words then ch_vld low -> after 8 idle cycles pktend_n low one cycle, slwr_n high; without macro, no pktend, still in WRITE.

Source files
------------

// File: rtl/fx3_bulkin_mux.sv
// fx3_bulkin_mux: round-robin writer of CH_NUM ready/valid streams into FX3 slave-FIFO sockets.
// Latency: a word accepted at edge N is on fx3_dout with fx3_slwr_n low during cycle N+1.
// Backpressure: ch_rdy only to the granted channel in WRITE; fx3_flaga low skips that channel's turn.
// Optional: define FX3_PKTEND_TIMEOUT_EN to commit a starved partial packet after TIMEOUT_CYC idle cycles.
module fx3_bulkin_mux #(
  parameter int CH_NUM      = 2,
  parameter int DATA_W      = 32,
  parameter int PKT_WORDS   = 256,
  parameter int FLAG_LAT    = 3,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     fx3_clk,
  input  logic                     fx3_rst,
  input  logic                     frame_rst_fx3,
  input  logic [CH_NUM-1:0]        ch_vld,
  input  logic [CH_NUM*DATA_W-1:0] ch_data,
  input  logic [CH_NUM-1:0]        ch_last,
  output logic [CH_NUM-1:0]        ch_rdy,
  output logic [CH_NUM-1:0]        ch_done,
  input  logic                     fx3_flaga,
  output logic [1:0]               fx3_a,
  output logic [DATA_W-1:0]        fx3_dout,
  output logic                     fx3_slwr_n,
  output logic                     fx3_pktend_n,
  output logic                     busy,
  output logic [31:0]              word_cnt
);

  localparam int PKT_CW = $clog2(PKT_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CHECK,
    S_WRITE,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [2:0]          cyc_q, cyc_d;
  logic [PKT_CW-1:0]   pkt_q, pkt_d;

  logic                arb_any;
  logic [1:0]          arb_g;
  int                  arb_best;
  logic [1:0]          nxt_ptr;

  logic                sel_vld;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;

  logic                accept;
  logic                short_end;
  logic                time_end;
  logic [CH_NUM-1:0]   rdy_d;
  logic [CH_NUM-1:0]   done_d;
  logic                clr;

  assign clr = fx3_rst | frame_rst_fx3;

`ifdef FX3_PKTEND_TIMEOUT_EN
  localparam int TO_CW = $clog2(TIMEOUT_CYC + 1);
  logic [TO_CW-1:0]    idle_q, idle_d;
`else
  // Keeps the timeout parameter referenced when the timeout path is compiled out.
  logic                timeout_unused;
  assign timeout_unused = (TIMEOUT_CYC != 0);
`endif

  // Round-robin pick: valid channel with the smallest distance upward from ptr.
  always_comb begin
    arb_any  = 1'b0;
    arb_g    = 2'd0;
    arb_best = CH_NUM;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_vld[i] && (((i + CH_NUM - int'(ptr_q)) % CH_NUM) < arb_best)) begin
        arb_best = (i + CH_NUM - int'(ptr_q)) % CH_NUM;
        arb_g    = 2'(i);
        arb_any  = 1'b1;
      end
    end
  end

  // Pointer moves one past the channel that just had its turn.
  assign nxt_ptr = (grant_q == 2'(CH_NUM - 1)) ? 2'd0 : grant_q + 2'd1;

  // Mux the granted channel's stream.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (grant_q == 2'(i)) begin
        sel_vld  = ch_vld[i];
        sel_last = ch_last[i];
        sel_data = ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic and per-cycle write/commit decisions.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cyc_d     = cyc_q;
    pkt_d     = pkt_q;
    accept    = 1'b0;
    short_end = 1'b0;
    time_end  = 1'b0;
`ifdef FX3_PKTEND_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          grant_d = arb_g;
          cyc_d   = 3'(FLAG_LAT - 1);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        // Give fx3_flaga time to reflect the newly addressed socket.
        if (cyc_q == 3'd0) state_d = S_CHECK;
        else               cyc_d   = cyc_q - 3'd1;
      end
      S_CHECK: begin
        if (fx3_flaga) begin
          pkt_d   = '0;
          state_d = S_WRITE;
`ifdef FX3_PKTEND_TIMEOUT_EN
          idle_d  = '0;
`endif
        end else begin
          // Socket full: forfeit this turn without touching the bus.
          ptr_d   = nxt_ptr;
          cyc_d   = 3'(GAP_CYC - 1);
          state_d = S_GAP;
        end
      end
      S_WRITE: begin
        if (sel_vld) begin
          accept = 1'b1;
          pkt_d  = pkt_q + PKT_CW'(1);
`ifdef FX3_PKTEND_TIMEOUT_EN
          idle_d = '0;
`endif
          if (pkt_q + PKT_CW'(1) == PKT_CW'(PKT_WORDS)) begin
            // Full packet commits itself; ch_last here needs no pktend.
            ptr_d   = nxt_ptr;
            cyc_d   = 3'(GAP_CYC - 1);
            state_d = S_GAP;
          end else if (sel_last) begin
            short_end = 1'b1;
            ptr_d     = nxt_ptr;
            cyc_d     = 3'(GAP_CYC - 1);
            state_d   = S_GAP;
          end
        end else begin
`ifdef FX3_PKTEND_TIMEOUT_EN
          if (idle_q != TO_CW'(TIMEOUT_CYC)) idle_d = idle_q + TO_CW'(1);
          // An empty packet never times out; only a partial one is committed.
          if ((idle_q == TO_CW'(TIMEOUT_CYC - 1)) && (pkt_q != '0)) begin
            time_end = 1'b1;
            ptr_d    = nxt_ptr;
            cyc_d    = 3'(GAP_CYC - 1);
            state_d  = S_GAP;
          end
`endif
        end
      end
      S_GAP: begin
        if (cyc_q == 3'd0) state_d = S_IDLE;
        else               cyc_d   = cyc_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready and done vectors, decoded ahead of the output registers.
  always_comb begin
    rdy_d  = '0;
    done_d = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      rdy_d[i]  = (state_d == S_WRITE) && (grant_d == 2'(i));
      done_d[i] = accept && sel_last && (grant_q == 2'(i));
    end
  end

  // FSM state, grant, round-robin pointer and counters.
  always_ff @(posedge fx3_clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      grant_q <= 2'd0;
      ptr_q   <= 2'd0;
      cyc_q   <= 3'd0;
      pkt_q   <= '0;
`ifdef FX3_PKTEND_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cyc_q   <= cyc_d;
      pkt_q   <= pkt_d;
`ifdef FX3_PKTEND_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

  // Registered pin and status outputs; a clear abandons any partial packet silently.
  always_ff @(posedge fx3_clk) begin
    if (clr) begin
      fx3_dout     <= '0;
      fx3_slwr_n   <= 1'b1;
      fx3_pktend_n <= 1'b1;
      ch_rdy       <= '0;
      ch_done      <= '0;
      busy         <= 1'b0;
      word_cnt     <= 32'd0;
    end else begin
      if (accept) fx3_dout <= sel_data;
      fx3_slwr_n   <= ~accept;
      fx3_pktend_n <= ~(short_end | time_end);
      ch_rdy       <= rdy_d;
      ch_done      <= done_d;
      busy         <= (state_d != S_IDLE);
      word_cnt     <= word_cnt + 32'(accept);
    end
  end

  // The grant register only changes on IDLE exit, so it holds the socket steady through GAP.
  assign fx3_a = grant_q;

endmodule

// File: tb/tb_fx3_bulkin_mux.sv
// Directed bench for fx3_bulkin_mux: CH_NUM=2, PKT_WORDS=16, FLAG_LAT=3, GAP_CYC=2, TIMEOUT_CYC=8.
module tb_fx3_bulkin_mux;

  logic        fx3_clk = 1'b0;
  logic        fx3_rst = 1'b1;
  logic        frame_rst_fx3 = 1'b0;
  logic [1:0]  ch_vld = '0;
  logic [63:0] ch_data = '0;
  logic [1:0]  ch_last = '0;
  logic [1:0]  ch_rdy;
  logic [1:0]  ch_done;
  logic        fx3_flaga = 1'b1;
  logic [1:0]  fx3_a;
  logic [31:0] fx3_dout;
  logic        fx3_slwr_n;
  logic        fx3_pktend_n;
  logic        busy;
  logic [31:0] word_cnt;

  fx3_bulkin_mux #(
    .CH_NUM(2), .DATA_W(32), .PKT_WORDS(16), .FLAG_LAT(3), .GAP_CYC(2), .TIMEOUT_CYC(8)
  ) dut (
    .fx3_clk(fx3_clk), .fx3_rst(fx3_rst), .frame_rst_fx3(frame_rst_fx3),
    .ch_vld(ch_vld), .ch_data(ch_data), .ch_last(ch_last), .ch_rdy(ch_rdy), .ch_done(ch_done),
    .fx3_flaga(fx3_flaga), .fx3_a(fx3_a), .fx3_dout(fx3_dout), .fx3_slwr_n(fx3_slwr_n),
    .fx3_pktend_n(fx3_pktend_n), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 fx3_clk = ~fx3_clk;

  int tests = 0;
  int fails = 0;

  // Source model per channel.
  bit          en[2];
  bit          has_last[2];
  int          len[2];
  int          sent[2];
  logic [31:0] base[2];

  // Observed pin activity.
  int          cyc = 0;
  int          run = 0;
  int          pe_cnt = 0;
  int          done_cnt[2];
  logic [1:0]  wr_a[$];
  logic [31:0] wr_d[$];
  logic        wr_pe[$];
  logic [1:0]  wr_done[$];
  int          burst_len[$];
  logic [1:0]  burst_sock[$];
  int          burst_start[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      ch_vld[i]           = en[i] && (sent[i] < len[i]);
      ch_data[i*32 +: 32] = base[i] + 32'(sent[i]);
      ch_last[i]          = has_last[i] && (sent[i] + 1 == len[i]);
    end
  endtask

  task automatic mon_clear();
    run = 0;
    pe_cnt = 0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    wr_a.delete(); wr_d.delete(); wr_pe.delete(); wr_done.delete();
    burst_len.delete(); burst_sock.delete(); burst_start.delete();
  endtask

  // Record the current cycle, let one clock edge pass, then update the sources.
  task automatic step();
    logic [1:0] acc;
    cyc++;
    if (!fx3_slwr_n) begin
      if (run == 0) begin
        burst_sock.push_back(fx3_a);
        burst_start.push_back(cyc);
      end
      run++;
      wr_a.push_back(fx3_a);
      wr_d.push_back(fx3_dout);
      wr_pe.push_back(fx3_pktend_n);
      wr_done.push_back(ch_done);
    end else if (run > 0) begin
      burst_len.push_back(run);
      run = 0;
    end
    if (!fx3_pktend_n) pe_cnt++;
    for (int i = 0; i < 2; i++) if (ch_done[i]) done_cnt[i]++;
    acc = ch_vld & ch_rdy;
    @(posedge fx3_clk);
    @(negedge fx3_clk);
    for (int i = 0; i < 2; i++) if (acc[i]) sent[i]++;
    drive();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    fx3_rst = 1'b1;
    en[0] = 1'b0; en[1] = 1'b0;
    sent[0] = 0;  sent[1] = 0;
    drive();
    steps(2);
    fx3_rst = 1'b0;
    mon_clear();
  endtask

  task automatic run_until_sent(input int n0, input int n1, input int bound, input string tag);
    int k;
    k = 0;
    while ((sent[0] < n0 || sent[1] < n1) && k < bound) begin
      step();
      k++;
    end
    check(tag, 64'((sent[0] >= n0) && (sent[1] >= n1)), 64'(1));
  endtask

  function automatic int data_errors();
    int nexp[2];
    int err;
    nexp[0] = 0; nexp[1] = 0; err = 0;
    foreach (wr_d[k]) begin
      if (wr_a[k] > 2'd1) err++;
      else if (wr_d[k] !== base[wr_a[k]] + 32'(nexp[wr_a[k]])) err++;
      else nexp[wr_a[k]]++;
    end
    return err;
  endfunction

  initial begin
    int k;
    en[0] = 0; en[1] = 0; has_last[0] = 0; has_last[1] = 0;
    len[0] = 0; len[1] = 0; sent[0] = 0; sent[1] = 0;
    base[0] = 32'h0; base[1] = 32'h0;

    // Reset values.
    do_reset();
    check("rst_slwr_n",   64'(fx3_slwr_n),   64'(1));
    check("rst_pktend_n", 64'(fx3_pktend_n), 64'(1));
    check("rst_a",        64'(fx3_a),        64'(0));
    check("rst_dout",     64'(fx3_dout),     64'(0));
    check("rst_rdy",      64'(ch_rdy),       64'(0));
    check("rst_done",     64'(ch_done),      64'(0));
    check("rst_busy",     64'(busy),         64'(0));
    check("rst_word_cnt", 64'(word_cnt),     64'(0));

    // A: ch0 streams 32 words, last on the 32nd -> two full packets on socket 0.
    base[0] = 32'hA000_0000; len[0] = 32; has_last[0] = 1; en[0] = 1;
    drive();
    k = 0;
    while (ch_rdy[0] !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("A_rdy_latency", 64'(k), 64'(5));
    run_until_sent(32, 0, 300, "A_complete");
    steps(5);
    check("A_writes",      64'(wr_d.size()),  64'(32));
    check("A_bursts",      64'(burst_len.size()), 64'(2));
    check("A_burst0_len",  64'(burst_len[0]), 64'(16));
    check("A_burst1_len",  64'(burst_len[1]), 64'(16));
    check("A_sock0",       64'(burst_sock[0]), 64'(0));
    check("A_sock1",       64'(burst_sock[1]), 64'(0));
    check("A_period",      64'(burst_start[1] - burst_start[0]), 64'(23));
    check("A_pktend",      64'(pe_cnt),       64'(0));
    check("A_done0",       64'(done_cnt[0]),  64'(1));
    check("A_data",        64'(data_errors()), 64'(0));
    check("A_word_cnt",    64'(word_cnt),     64'(32));
    check("A_dout_hold",   64'(fx3_dout),     64'(32'hA000_001F));
    check("A_idle_busy",   64'(busy),         64'(0));

    // B: both channels continuously valid -> sockets alternate per packet.
    do_reset();
    base[0] = 32'hA100_0000; len[0] = 48; has_last[0] = 1; en[0] = 1;
    base[1] = 32'hB100_0000; len[1] = 48; has_last[1] = 1; en[1] = 1;
    drive();
    run_until_sent(48, 48, 600, "B_complete");
    steps(5);
    check("B_bursts", 64'(burst_len.size()), 64'(6));
    foreach (burst_len[j]) begin
      check($sformatf("B_sock%0d", j), 64'(burst_sock[j]), 64'(j % 2));
      check($sformatf("B_len%0d", j),  64'(burst_len[j]),  64'(16));
    end
    check("B_data",     64'(data_errors()), 64'(0));
    check("B_pktend",   64'(pe_cnt),        64'(0));
    check("B_done0",    64'(done_cnt[0]),   64'(1));
    check("B_done1",    64'(done_cnt[1]),   64'(1));
    check("B_word_cnt", 64'(word_cnt),      64'(96));

    // C: ch1 short transfer of 5 words -> pktend and ch_done with the 5th strobe.
    do_reset();
    base[1] = 32'hC100_0000; len[1] = 5; has_last[1] = 1; en[1] = 1;
    drive();
    run_until_sent(0, 5, 100, "C_complete");
    steps(4);
    check("C_writes",     64'(wr_d.size()), 64'(5));
    check("C_sock",       64'(burst_sock[0]), 64'(1));
    check("C_data",       64'(data_errors()), 64'(0));
    check("C_pktend_cnt", 64'(pe_cnt),      64'(1));
    check("C_pktend_w4",  64'(wr_pe[4]),    64'(0));
    check("C_pktend_w3",  64'(wr_pe[3]),    64'(1));
    check("C_done_w4",    64'(wr_done[4]),  64'(2'b10));
    check("C_done_cnt",   64'(done_cnt[1]), 64'(1));
    check("C_word_cnt",   64'(word_cnt),    64'(5));

    // D: socket 0 full at its CHECK while ch1 waits -> ch1 goes first, ch0 afterwards.
    do_reset();
    fx3_flaga = 1'b0;
    base[0] = 32'hD000_0000; len[0] = 3; has_last[0] = 1; en[0] = 1;
    base[1] = 32'hD100_0000; len[1] = 3; has_last[1] = 1; en[1] = 1;
    drive();
    steps(5);
    check("D_no_write_yet", 64'(wr_d.size()), 64'(0));
    check("D_addr_ch0",     64'(fx3_a),       64'(0));
    fx3_flaga = 1'b1;
    run_until_sent(3, 3, 300, "D_complete");
    steps(5);
    check("D_bursts",  64'(burst_len.size()), 64'(2));
    check("D_first",   64'(burst_sock[0]), 64'(1));
    check("D_second",  64'(burst_sock[1]), 64'(0));
    check("D_writes",  64'(wr_d.size()),   64'(6));
    check("D_data",    64'(data_errors()), 64'(0));
    check("D_pktend",  64'(pe_cnt),        64'(2));

    // E: frame_rst_fx3 after 7 words of a packet abandons it without pktend.
    do_reset();
    base[0] = 32'hE000_0000; len[0] = 100; has_last[0] = 0; en[0] = 1;
    drive();
    run_until_sent(7, 0, 100, "E_seven");
    check("E_word_cnt7", 64'(word_cnt),   64'(7));
    check("E_slwr_on",   64'(fx3_slwr_n), 64'(0));
    en[0] = 0;
    drive();
    frame_rst_fx3 = 1'b1;
    step();
    check("E_slwr_n",   64'(fx3_slwr_n),   64'(1));
    check("E_pktend_n", 64'(fx3_pktend_n), 64'(1));
    check("E_busy",     64'(busy),         64'(0));
    check("E_word_cnt", 64'(word_cnt),     64'(0));
    check("E_rdy",      64'(ch_rdy),       64'(0));
    frame_rst_fx3 = 1'b0;
    steps(3);
    check("E_pktend_cnt", 64'(pe_cnt), 64'(0));
    check("E_busy_after", 64'(busy),   64'(0));

    // F: 3 words, then the channel goes quiet.
    do_reset();
    base[0] = 32'hF000_0000; len[0] = 3; has_last[0] = 0; en[0] = 1;
    drive();
    run_until_sent(3, 0, 50, "F_three");
    steps(7);
    check("F_pktend_early", 64'(fx3_pktend_n), 64'(1));
    step();
`ifdef FX3_PKTEND_TIMEOUT_EN
    check("F_pktend_low",  64'(fx3_pktend_n), 64'(0));
    check("F_slwr_high",   64'(fx3_slwr_n),   64'(1));
    check("F_rdy_dropped", 64'(ch_rdy),       64'(0));
    step();
    check("F_pktend_one",  64'(fx3_pktend_n), 64'(1));
    check("F_busy_gap",    64'(busy),         64'(1));
    steps(4);
    check("F_pktend_cnt",  64'(pe_cnt),       64'(1));
    check("F_busy_idle",   64'(busy),         64'(0));
`else
    check("F_no_pktend",   64'(fx3_pktend_n), 64'(1));
    steps(20);
    check("F_pktend_cnt",  64'(pe_cnt),       64'(0));
    check("F_still_write", 64'(ch_rdy),       64'(2'b01));
    check("F_busy",        64'(busy),         64'(1));
`endif
    check("F_done_none", 64'(done_cnt[0]), 64'(0));
    check("F_word_cnt",  64'(word_cnt),    64'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
